// File: rtl/param_memory.sv
// Single-port synchronous RAM with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write policy and a zeroing sweep after reset or clear.
module param_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                    Clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   Data_in,
  input  logic [ADDR_WIDTH-1:0]   Address,
  input  logic                    write_En,
  input  logic                    read_En,
  input  logic [DATA_WIDTH/8-1:0] byte_En,
  input  logic                    clear,
  output logic [DATA_WIDTH-1:0]   Data_out,
  output logic                    rd_valid,
  output logic                    busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {SWEEP, READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    accept;
  logic                    wr_fire, rd_fire;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data, old_word, merged, rd_word;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d, stage_q, stage_d;
  logic                    valid_q, valid_d, stage_v_q, stage_v_d;

  // State, sweep counter and read pipeline registers
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q   <= SWEEP;
      cnt_q     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      stage_q   <= '0;
      stage_v_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      stage_q   <= stage_d;
      stage_v_q <= stage_v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = READY;
      end
      READY: begin
        if (clear) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  always_comb begin
    old_word = mem_q[Address];
    merged   = old_word;
    for (int unsigned i = 0; i < NB; i++) begin
      if (byte_En[i]) merged[8*i +: 8] = Data_in[8*i +: 8];
    end

    accept  = (state_q == READY) && !clear;
    wr_fire = (accept && write_En) || (state_q == SWEEP);
    wr_addr = (state_q == SWEEP) ? cnt_q[ADDR_WIDTH-1:0] : Address;
    wr_data = (state_q == SWEEP) ? '0 : merged;
    rd_fire = accept && read_En;
    // One address port, so a concurrent write always targets the read word
    rd_word = (RDW_MODE == 1 && write_En) ? merged : old_word;

    dout_d    = dout_q;
    valid_d   = 1'b0;
    stage_d   = stage_q;
    stage_v_d = 1'b0;
    if (RD_LATENCY == 2) begin
      if (rd_fire) stage_d = rd_word;
      stage_v_d = rd_fire;
      if (stage_v_q) begin
        dout_d  = stage_q;
        valid_d = 1'b1;
      end
    end else begin
      if (rd_fire) begin
        dout_d  = rd_word;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_fire) mem_q[wr_addr] <= wr_data;
  end

  assign Data_out = dout_q;
  assign rd_valid = valid_q;
  assign busy     = (state_q == SWEEP);

endmodule

// File: tb/tb_param_memory.sv
// Scoreboard bench: two instances (latency 1/old-data and latency 2/new-data)
// share stimulus; each has its own expected-response queue and monitor.
module tb_param_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic [3:0]  addr;
  logic        we, re, clr;
  logic [3:0]  be;
  logic [31:0] dout0, dout1;
  logic        rv0, rv1, busy0, busy1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  param_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(1), .RDW_MODE(0)) dut0 (
    .Clk(clk), .rst(rst), .Data_in(din), .Address(addr), .write_En(we), .read_En(re),
    .byte_En(be), .clear(clr), .Data_out(dout0), .rd_valid(rv0), .busy(busy0)
  );

  param_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(2), .RDW_MODE(1)) dut1 (
    .Clk(clk), .rst(rst), .Data_in(din), .Address(addr), .write_En(we), .read_En(re),
    .byte_En(be), .clear(clr), .Data_out(dout1), .rd_valid(rv1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rv0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_valid0 at cycle %0d: got 1 expected 0", cyc);
      end else begin
        e = q0.pop_front();
        check("rd_data0", dout0, e.data);
        check("rd_cycle0", cyc, e.cyc);
      end
    end
    if (rv1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_valid1 at cycle %0d: got 1 expected 0", cyc);
      end else begin
        e = q1.pop_front();
        check("rd_data1", dout1, e.data);
        check("rd_cycle1", cyc, e.cyc);
      end
    end
  end

  // Called at a falling edge; the request is taken on the next rising edge.
  task automatic issue(input logic w, input logic r, input logic c, input logic [3:0] a,
                       input logic [3:0] b, input logic [31:0] d,
                       input logic [31:0] e0, input logic [31:0] e1, input logic exp_rd);
    we = w; re = r; clr = c; addr = a; be = b; din = d;
    if (exp_rd) begin
      q0.push_back('{e0, cyc + 1});
      q1.push_back('{e1, cyc + 2});
    end
    @(negedge clk);
    we = 1'b0; re = 1'b0; clr = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
    issue(1'b1, 1'b0, 1'b0, a, b, d, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e0, input logic [31:0] e1);
    issue(1'b0, 1'b1, 1'b0, a, 4'hF, 32'h0, e0, e1, 1'b1);
  endtask

  // Counts rising edges until busy falls; drops any held requests right then.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    forever begin
      @(posedge clk);
      cnt++;
      #1;
      if (!busy0 || cnt > 100) break;
    end
    we = 1'b0; re = 1'b0; clr = 1'b0;
    check("busy1_matches", {31'b0, busy1}, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; din = '0; addr = '0; we = 1'b0; re = 1'b0; clr = 1'b0; be = '0;
    #12;
    check("rst_dout0", dout0, 32'h0);
    check("rst_rv0", {31'b0, rv0}, 32'h0);
    check("rst_busy0", {31'b0, busy0}, 32'h1);
    check("rst_busy1", {31'b0, busy1}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    check("busy_edges_reset", n, 16);

    for (int i = 0; i < 16; i++) rd(4'(i), 32'h0, 32'h0);

    wr(4'd3, 4'b1111, 32'hAABBCCDD);
    wr(4'd3, 4'b0101, 32'h11223344);
    rd(4'd3, 32'hAA22CC44, 32'hAA22CC44);
    wr(4'd3, 4'b0000, 32'hFFFFFFFF);
    rd(4'd3, 32'hAA22CC44, 32'hAA22CC44);

    wr(4'd1, 4'hF, 32'h00000011);
    wr(4'd2, 4'hF, 32'h00000022);
    rd(4'd1, 32'h00000011, 32'h00000011);
    rd(4'd2, 32'h00000022, 32'h00000022);
    rd(4'd3, 32'hAA22CC44, 32'hAA22CC44);

    wr(4'd5, 4'hF, 32'h00000001);
    issue(1'b1, 1'b1, 1'b0, 4'd5, 4'hF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b1);
    rd(4'd5, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(1'b1, 1'b1, 1'b0, 4'd5, 4'b0011, 32'h0000AAAA, 32'hFFFFFFFF, 32'hFFFFAAAA, 1'b1);
    rd(4'd5, 32'hFFFFAAAA, 32'hFFFFAAAA);

    repeat (3) @(negedge clk);
    check("hold_dout0", dout0, 32'hFFFFAAAA);
    check("hold_dout1", dout1, 32'hFFFFAAAA);
    check("hold_rv0", {31'b0, rv0}, 32'h0);

    // Read in flight across the clear edge; clear beats the write on that edge
    wr(4'd7, 4'hF, 32'h00000055);
    rd(4'd7, 32'h00000055, 32'h00000055);
    we = 1'b1; re = 1'b1; clr = 1'b1; addr = 4'd7; be = 4'hF; din = 32'h00001234;
    @(posedge clk);
    #1;
    check("busy_after_clear", {31'b0, busy0}, 32'h1);
    wait_ready(n);
    check("busy_edges_clear", n, 16);
    rd(4'd7, 32'h0, 32'h0);
    rd(4'd3, 32'h0, 32'h0);
    rd(4'd5, 32'h0, 32'h0);

    // Reset while dut1 still has a read in its stage register
    wr(4'd9, 4'hF, 32'hDEADBEEF);
    rd(4'd9, 32'hDEADBEEF, 32'hDEADBEEF);
    #1;
    rst = 1'b1;
    q1.delete();
    #1;
    check("midrd_dout0", dout0, 32'h0);
    check("midrd_dout1", dout1, 32'h0);
    check("midrd_rv0", {31'b0, rv0}, 32'h0);
    check("midrd_rv1", {31'b0, rv1}, 32'h0);
    check("midrd_busy0", {31'b0, busy0}, 32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    check("busy_edges_rst_rd", n, 16);
    rd(4'd9, 32'h0, 32'h0);

    // Reset at sweep edge 8 restarts the full sweep
    wr(4'd4, 4'hF, 32'hCAFEF00D);
    rd(4'd4, 32'hCAFEF00D, 32'hCAFEF00D);
    rd(4'd4, 32'hCAFEF00D, 32'hCAFEF00D);
    issue(1'b0, 1'b0, 1'b1, 4'd0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midsw_dout0", dout0, 32'h0);
    check("midsw_dout1", dout1, 32'h0);
    check("midsw_busy0", {31'b0, busy0}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    check("busy_edges_rst_sw", n, 16);
    rd(4'd4, 32'h0, 32'h0);
    rd(4'd15, 32'h0, 32'h0);

    repeat (4) @(negedge clk);
    check("q0_drained", q0.size(), 32'h0);
    check("q1_drained", q1.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
